// File: rtl/line_buf3.sv
// line_buf3: two-line buffer in front of the 3x3 convolution stage.
// Each accepted raster-order ARGB32 pixel is presented together with the
// pixels at the same column from the two previous lines (top = r-2, mid =
// r-1, bot = r). The fill FSM marks which columns carry a complete window.
module line_buf3 #(
  parameter int LINE_W  = 640,
  parameter int FRAME_H = 480,
  parameter int COLW    = $clog2(LINE_W),
  parameter int ROWW    = $clog2(FRAME_H)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic            in_sof,
  input  logic [31:0]     in_pix,
  output logic [31:0]     top_pix,
  output logic [31:0]     mid_pix,
  output logic [31:0]     bot_pix,
  output logic            shift_en,
  output logic            win_valid,
  output logic [COLW-1:0] out_col,
  output logic [ROWW-1:0] out_row,
  output logic            out_eof
);

  // Fill progress within a frame: row 0, row 1, then rows that have two
  // real lines above them.
  typedef enum logic [1:0] {
    FILL0  = 2'd0,
    FILL1  = 2'd1,
    STREAM = 2'd2
  } state_t;

  localparam logic [COLW-1:0] COL_LAST = COLW'(LINE_W - 1);
  localparam logic [ROWW-1:0] ROW_LAST = ROWW'(FRAME_H - 1);

  state_t          state_q, state_d;
  logic [COLW-1:0] col_q, col_d;
  logic [ROWW-1:0] row_q, row_d;

  // Position of the pixel being accepted this cycle (after any resync).
  state_t          acc_state;
  logic [COLW-1:0] acc_col;
  logic [ROWW-1:0] acc_row;
  logic            col_last;
  logic            row_last;

  // Line memories: l1 holds row r-1, l2 holds row r-2.
  logic [31:0] l1_mem [LINE_W];
  logic [31:0] l2_mem [LINE_W];

  // Resolve the accepted pixel position and compute the next counter/FSM state.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    acc_state = state_q;
    acc_col   = col_q;
    acc_row   = row_q;
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;

    // A start-of-frame marker re-anchors this pixel to row 0, col 0 from
    // anywhere; stale line data stays masked because the FSM restarts.
    if (in_valid && in_sof) begin
      acc_state = FILL0;
      acc_col   = '0;
      acc_row   = '0;
    end

    col_last = (acc_col == COL_LAST);
    row_last = (acc_row == ROW_LAST);

    if (in_valid) begin
      if (col_last) begin
        col_d = '0;
        if (row_last) begin
          row_d   = '0;
          state_d = FILL0;
        end else begin
          row_d = acc_row + ROWW'(1);
          unique case (acc_state)
            FILL0:   state_d = FILL1;
            FILL1:   state_d = STREAM;
            STREAM:  state_d = STREAM;
            default: state_d = FILL0;
          endcase
        end
      end else begin
        col_d   = acc_col + COLW'(1);
        row_d   = acc_row;
        state_d = acc_state;
      end
    end
  end

  // Position counters and fill FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  // Line memories: shift the accepted column down one line.
  always_ff @(posedge clk) begin
    // NOTE: the line memories are deliberately not reset; their contents
    // are only trusted once the FSM has refilled them, and a reset here
    // would prevent mapping them to RAM.
    if (in_valid) begin
      l2_mem[acc_col] <= l1_mem[acc_col];
      l1_mem[acc_col] <= in_pix;
    end
  end

  // Registered column outputs; reads see the memories before this edge's write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_pix   <= '0;
      mid_pix   <= '0;
      bot_pix   <= '0;
      shift_en  <= 1'b0;
      win_valid <= 1'b0;
      out_col   <= '0;
      out_row   <= '0;
      out_eof   <= 1'b0;
    end else begin
      shift_en  <= in_valid;
      win_valid <= in_valid && (acc_state == STREAM);
      out_eof   <= in_valid && col_last && row_last;
      if (in_valid) begin
        top_pix <= l2_mem[acc_col];
        mid_pix <= l1_mem[acc_col];
        bot_pix <= in_pix;
        out_col <= acc_col;
        out_row <= acc_row;
      end
    end
  end

endmodule
